// File: rtl/clock_pkg.sv
// Shared BCD limits, default prescale ratio and BCD helpers for the time base.
// Used by time_base_counter and clk_tick_gen.
package clock_pkg;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] HOUR_NOON = 8'h12;

  localparam int TICK_DIV_DEFAULT = 50_000_000;

  // Illegal digits collapse to 0 so a corrupted field recovers on the next tick.
  function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    r = v;
    if (r[3:0] > 4'd9)     r[3:0] = 4'd0;
    if (r[7:4] > max[7:4]) r[7:4] = 4'd0;
    if (r > max)           r = 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] c;
    c = bcd_clean(v, max);
    if (c >= max)
      return 8'h00;
    else if (c[3:0] == 4'd9)
      return {c[7:4] + 4'd1, 4'd0};
    else
      return {c[7:4], c[3:0] + 4'd1};
  endfunction

  // BCD 24h -> 12h: 00 shows as 12, 13..23 drop by twelve with a digit borrow.
  function automatic logic [7:0] hour_to_12(input logic [7:0] h);
    if (h == 8'h00)
      return HOUR_NOON;
    else if (h <= HOUR_NOON)
      return h;
    else if (h[3:0] >= 4'd2)
      return {h[7:4] - 4'd1, h[3:0] - 4'd2};
    else
      return {h[7:4] - 4'd2, h[3:0] + 4'd8};
  endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Prescaler dividing the system clock down to a single-cycle tick every
// TICK_DIV cycles; free-running, cleared only by the synchronous reset.
module clk_tick_gen
  import clock_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/time_base_counter.sv
// BCD hh:mm:ss timekeeping core with adjust inputs and 24h/12h display.
// Optional hourly chime enabled by defining HOURLY_CHIME_EN.
module time_base_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       CP50,
  input  logic       CR,
  input  logic       EN,
  input  logic       Ctrl24To12,
  input  logic       AdjH,
  input  logic       AdjM,
  output logic [7:0] HourOut,
  output logic [7:0] MinOut,
  output logic [7:0] SecOut,
  output logic       PM,
  output logic       Tick1Hz,
  output logic       Chime
);

  logic       tick;
  logic [7:0] sec, min, hour;
  logic [7:0] sec_next, min_next, hour_next;
  logic       sec_carry, min_carry;

  clk_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (CP50),
    .rst  (CR),
    .tick (tick)
  );

  // Adjust merges with a carry on the same tick so a field never steps twice;
  // only normal counting carries upward, an adjust wrap stays in its field.
  always_comb begin
    sec_carry = EN && (bcd_clean(sec, SEC_MAX) == SEC_MAX);
    min_carry = sec_carry && (bcd_clean(min, MIN_MAX) == MIN_MAX);
    sec_next  = EN ? bcd_inc(sec, SEC_MAX) : bcd_clean(sec, SEC_MAX);
    min_next  = (sec_carry || AdjM) ? bcd_inc(min, MIN_MAX) : bcd_clean(min, MIN_MAX);
    hour_next = (min_carry || AdjH) ? bcd_inc(hour, HOUR_MAX) : bcd_clean(hour, HOUR_MAX);
  end

  always_ff @(posedge CP50) begin
    if (CR) begin
      sec  <= 8'h00;
      min  <= 8'h00;
      hour <= 8'h00;
    end else if (tick) begin
      sec  <= sec_next;
      min  <= min_next;
      hour <= hour_next;
    end
  end

  assign Tick1Hz = tick;
  assign SecOut  = sec;
  assign MinOut  = min;
  assign HourOut = Ctrl24To12 ? hour_to_12(hour) : hour;
  assign PM      = (hour >= HOUR_NOON);

`ifdef HOURLY_CHIME_EN
  logic       chime_r;
  logic [7:0] sec_view, min_view;

  // Chime follows the value the registers take on this edge so it lines up with SecOut.
  always_comb begin
    sec_view = tick ? sec_next : sec;
    min_view = tick ? min_next : min;
  end

  always_ff @(posedge CP50) begin
    if (CR)
      chime_r <= 1'b0;
    else
      chime_r <= (min_view == MIN_MAX) && (sec_view[7:4] == 4'd5) &&
                 sec_view[0] && (sec_view[3:0] <= 4'd9);
  end

  assign Chime = chime_r;
`else
  assign Chime = 1'b0;
`endif

endmodule

// File: doc/time_base_counter.md
Name: time_base_counter

Overview:
BCD hour/minute/second timekeeping core for the digital clock. It divides CP50 down to a 1 Hz tick and keeps time in 24-hour form. It applies hour/minute adjust requests and presents display-ready BCD hours (24h or 12h with PM flag), minutes and seconds. It feeds the HEX display/alarm stage directly downstream.

Parameters:
TICK_DIV, 50000000, CP50 cycles per 1 Hz tick; bench uses 4.

Ports:
CP50  in  1  system clock, 50 MHz
CR  in  1  reset, synchronous, active-high
EN  in  1  timekeeping enable; 0 freezes normal counting
Ctrl24To12  in  1  0 = 24h display, 1 = 12h display
AdjH  in  1  level; while high, hour +1 per tick
AdjM  in  1  level; while high, minute +1 per tick
HourOut  out  8  BCD display hour (00-23 or 01-12)
MinOut  out  8  BCD minute 00-59
SecOut  out  8  BCD second 00-59
PM  out  1  1 when internal hour >= 12, in either mode
Tick1Hz  out  1  one-CP50-cycle pulse per tick
Chime  out  1  hourly chime; see Optional Feature

Behaviour:
- One clock: CP50. Reset is synchronous and active-high (CR). CR dominates every other input.
- Reset values: prescaler count 0, Sec/Min/internal hour 00, Tick1Hz 0, Chime 0, PM 0. HourOut reads 00 in 24h mode and 12 in 12h mode.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - Tick1Hz is registered and high exactly on the cycle after count == TICK_DIV-1.
  - Runs independently of EN.
- All counter registers update on the edge where Tick1Hz = 1. Outputs show the new value the following cycle.
- Normal count (EN=1):
  - Sec counts BCD 00→59. At 59 → 00 with minute carry.
  - Min counts 00→59. At 59 on carry → 00 with hour carry.
  - Hour counts 00→23. At 23 → 00.
  - Low digit 9 → 0 increments the high digit.
- Adjust (independent of EN):
  - AdjM increments minute mod 60. Adjust wrap never carries into hour.
  - AdjH increments hour mod 24.
  - Seconds are untouched by adjust.
- Simultaneous events on one tick:
  - Seconds carry + AdjM → minute +1 once. If minute was 59, the normal hour carry applies.
  - Minute carry into hour + AdjH → hour +1 once.
  - AdjH and AdjM together → both fields adjust.
- 12h conversion (combinational from registers):
  - Internal 0 → 12.
  - 1..12 → same.
  - 13..23 → hour-12, BCD.
  - Ctrl24To12=0 → HourOut is the internal hour.
- Unreachable codes: no illegal BCD state is reachable from reset. Any decoded illegal digit is forced to 0 on the next tick.
- CR mid-count: the next edge clears everything, including the prescaler phase. The first post-reset tick arrives TICK_DIV cycles later.

Optional Feature:
HOURLY_CHIME_EN
- Defined: Chime is registered, high while Min=59 and Sec ∈ {51,53,55,57,59}, otherwise 0.
- Undefined: Chime tied to 0. The port remains for a stable interface.

Decomposition:
- Package clock_pkg:
  - BCD limit constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23, HOUR_NOON=8'h12.
  - Default TICK_DIV.
  - A BCD-increment-with-wrap function.
- One sub-module: clk_tick_gen (prescaler + Tick1Hz register), parameterised by TICK_DIV.

Test Plan:
1. CR=1 for 2 cycles mid-count, then 0 → HourOut=00, MinOut=00, SecOut=00, PM=0, Tick1Hz=0; with Ctrl24To12=1, HourOut=12. First Tick1Hz exactly 4 cycles after CR falls.
2. EN=1, 60 ticks → SecOut passes 09→10 and 59→00; MinOut=01 after tick 60.
3. EN=0, AdjH high 13 ticks → SecOut stays 00. Ctrl24To12=0: HourOut=13, PM=1. Ctrl24To12=1: HourOut=01, PM=1.
4. Set 23:59 by adjust, EN=1, 59 ticks → 23:59:59; next tick → 00:00:00, PM=0.
5. Time 10:59:59 with AdjM high on the next tick → 11:00:00, i.e. no double minute increment. Separately, time 10:58:30 with AdjM high → 10:59:31.
6. HOURLY_CHIME_EN defined: Chime=1 at xx:59:51, 0 at xx:59:52, 1 at xx:59:59, 0 at xx:00:00. Macro undefined: Chime constantly 0.
